// File: rtl/monitor_decimator_if.sv
// Sample/publish bundle between the FOC sampler, the decimator and the UART monitor.
// The master drives samples and observes the averages; the decimator sits on the slave side.
interface monitor_decimator_if;
  logic               i_en;
  logic               i_clear;
  logic signed [15:0] i_val0;
  logic signed [15:0] i_val1;
  logic signed [15:0] i_val2;
  logic signed [15:0] i_val3;
  logic               o_en;
  logic signed [15:0] o_val0;
  logic signed [15:0] o_val1;
  logic signed [15:0] o_val2;
  logic signed [15:0] o_val3;
  logic        [7:0]  o_drop_cnt;

  modport master (
    output i_en, i_clear, i_val0, i_val1, i_val2, i_val3,
    input  o_en, o_val0, o_val1, o_val2, o_val3, o_drop_cnt
  );

  modport slave (
    input  i_en, i_clear, i_val0, i_val1, i_val2, i_val3,
    output o_en, o_val0, o_val1, o_val2, o_val3, o_drop_cnt
  );
endinterface

// File: rtl/monitor_decimator.sv
// Four-channel box-car averager that throttles its publish pulses so the
// downstream UART monitor is never overrun; averages landing inside the gap are dropped.

module monitor_decimator_lane #(
  parameter int AVG_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               take,
  input  logic               first,
  input  logic               clr,
  input  logic signed [15:0] val,
  output logic signed [15:0] avg
);
  localparam int ACC_W = 16 + AVG_SHIFT;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sx;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;

  // First sample of a block replaces the accumulator instead of adding to it.
  assign sx   = ACC_W'(val);
  assign base = first ? '0 : acc;
  assign sum  = base + sx;
  assign avg  = 16'(sum >>> AVG_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       acc <= '0;
    else if (clr)  acc <= '0;
    else if (take) acc <= sum;
  end
endmodule

module monitor_decimator #(
  parameter int AVG_SHIFT = 4,
  parameter int MIN_GAP   = 83328
) (
  input  logic                clk,
  input  logic                rst,
  monitor_decimator_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int SCNT_W    = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
  localparam int GAP_W     = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << AVG_SHIFT) - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = (MIN_GAP > 1) ? GAP_W'(MIN_GAP - 1) : '0;

  logic [NUM_LANES-1:0][15:0] vin;
  logic [NUM_LANES-1:0][15:0] avg;
  logic [NUM_LANES-1:0][15:0] o_val;
  logic [SCNT_W-1:0]          scnt;
  logic [GAP_W-1:0]           gap;
  logic [7:0]                 drop_cnt;
  logic                       o_en;
  logic                       take;
  logic                       first;
  logic                       last;

  assign vin   = {bus.i_val3, bus.i_val2, bus.i_val1, bus.i_val0};
  assign take  = bus.i_en & ~bus.i_clear;
  assign first = (scnt == '0);
  assign last  = (scnt == SCNT_LAST);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    monitor_decimator_lane #(.AVG_SHIFT(AVG_SHIFT)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .take  (take),
      .first (first),
      .clr   (bus.i_clear),
      .val   (vin[g]),
      .avg   (avg[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt     <= '0;
      gap      <= '0;
      drop_cnt <= '0;
      o_en     <= 1'b0;
      o_val    <= '0;
    end else begin
      o_en <= 1'b0;
      if (gap != '0) gap <= gap - GAP_W'(1);
      if (bus.i_clear) begin
        scnt <= '0;
      end else if (bus.i_en) begin
        if (last) begin
          scnt <= '0;
          // Publish only when the gap window has expired; otherwise count the loss.
          if (gap == '0) begin
            o_val <= avg;
            o_en  <= 1'b1;
            gap   <= GAP_LOAD;
          end else if (drop_cnt != 8'hff) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end else begin
          scnt <= scnt + SCNT_W'(1);
        end
      end
    end
  end

  assign bus.o_en       = o_en;
  assign bus.o_val0     = o_val[0];
  assign bus.o_val1     = o_val[1];
  assign bus.o_val2     = o_val[2];
  assign bus.o_val3     = o_val[3];
  assign bus.o_drop_cnt = drop_cnt;
endmodule
